// File: rtl/ahb_lite_slave_mem.sv
// AHB-Lite SRAM slave: word-addressed memory window with programmable wait states
// and the two-cycle ERROR response for out-of-range, oversized or misaligned beats.
module ahb_lite_slave_mem #(
    parameter int            AW          = 32,
    parameter int            DW          = 32,
    parameter int            RW          = 2,
    parameter int            MEM_DEPTH   = 1024,
    parameter logic [AW-1:0] BASE_ADDR   = '0,
    parameter int            WAIT_STATES = 0
) (
    input  logic          hclk,
    input  logic          hreset,
    input  logic          hsel,
    input  logic [AW-1:0] haddr,
    input  logic          hwrite,
    input  logic [2:0]    hsize,
    input  logic [2:0]    hburst,
    input  logic [3:0]    hprot,
    input  logic [1:0]    htrans,
    input  logic          hmastlock,
    input  logic          hready,
    input  logic [DW-1:0] hwdata,
    output logic [DW-1:0] hrdata,
    output logic          hreadyout,
    output logic [RW-1:0] hresp
);

    localparam int            BW    = DW / 8;
    localparam int            OFF_W = $clog2(BW);
    localparam int            IDX_W = $clog2(MEM_DEPTH);
    localparam logic [AW:0]   LIMIT = {1'b0, BASE_ADDR} + (AW+1)'(MEM_DEPTH * BW);
    localparam logic [RW-1:0] OKAY  = RW'(0);
    localparam logic [RW-1:0] ERROR = RW'(1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

    state_t          state;
    logic [3:0]      cnt;
    logic            hreadyout_r;
    logic [RW-1:0]   hresp_r;
    logic            vld_p1;
    logic [AW-1:0]   addr_p1;
    logic            write_p1;
    logic [2:0]      size_p1;
    logic [DW-1:0]   mem [MEM_DEPTH];
    logic            accept;
    logic            legal;
    logic [IDX_W-1:0] idx_p1;
    logic [BW-1:0]   wmask;

    function automatic logic beat_legal(input logic [AW-1:0] a, input logic [2:0] size);
        logic [7:0] amask;
        logic       in_range;
        amask    = (8'd1 << size) - 8'd1;
        in_range = ({1'b0, a} >= {1'b0, BASE_ADDR}) && ({1'b0, a} < LIMIT);
        return in_range && (size <= 3'(OFF_W)) && ((a[7:0] & amask) == 8'd0);
    endfunction

    // Lanes of the naturally aligned 2^size block that contains byte offset off.
    function automatic logic [BW-1:0] lane_mask(input logic [2:0] size, input logic [OFF_W-1:0] off);
        logic [BW-1:0] m;
        m = '0;
        for (int b = 0; b < BW; b++) begin
            if ((b >> size) == (int'(off) >> size)) m[b] = 1'b1;
        end
        return m;
    endfunction

    // Accepts are only taken while this slave is ready, which makes us robust to a stray hready.
    assign accept = hsel && hready && htrans[1] && hreadyout_r;
    assign legal  = beat_legal(haddr, hsize);
    assign idx_p1 = addr_p1[OFF_W +: IDX_W];
    assign wmask  = lane_mask(size_p1, addr_p1[OFF_W-1:0]);

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            hreadyout_r <= 1'b1;
            hresp_r     <= OKAY;
            vld_p1      <= 1'b0;
        end else begin
            case (state)
                S_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state       <= S_IDLE;
                        hreadyout_r <= 1'b1;
                    end
                end
                S_ERR1: begin
                    state       <= S_ERR2;
                    hreadyout_r <= 1'b1;
                end
                default: begin
                    state       <= S_IDLE;
                    hreadyout_r <= 1'b1;
                    hresp_r     <= OKAY;
                    vld_p1      <= 1'b0;
                    if (accept) begin
                        if (!legal) begin
                            state       <= S_ERR1;
                            hreadyout_r <= 1'b0;
                            hresp_r     <= ERROR;
                        end else begin
                            vld_p1 <= 1'b1;
                            if (WAIT_STATES != 0) begin
                                state       <= S_WAIT;
                                cnt         <= 4'(WAIT_STATES);
                                hreadyout_r <= 1'b0;
                            end
                        end
                    end
                end
            endcase
        end
    end

    // Address-phase capture into the data-phase registers.
    always_ff @(posedge hclk) begin
        if (accept) begin
            addr_p1  <= haddr;
            write_p1 <= hwrite;
            size_p1  <= hsize;
        end
    end

    // Write lands on the edge that ends the legal data phase.
    always_ff @(posedge hclk) begin
        if (vld_p1 && write_p1 && hreadyout_r && !hreset) begin
            for (int b = 0; b < BW; b++) begin
                if (wmask[b]) mem[idx_p1][b*8 +: 8] <= hwdata[b*8 +: 8];
            end
        end
    end

    assign hrdata    = (vld_p1 && !write_p1) ? mem[idx_p1] : '0;
    assign hreadyout = hreadyout_r;
    assign hresp     = hresp_r;

    logic unused_ok;
    assign unused_ok = ^{hburst, hprot, hmastlock, addr_p1};

endmodule
